// File: rtl/ofm_requant.sv
// OFM requantizer: accumulates PE partial sums per output group,
// adds bias, round-shifts, applies ReLU and saturates to OUT_W.
module ofm_requant #(
  parameter int IN_W  = 20,
  parameter int ACC_W = 28,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_num_psum,
  input  logic [15:0]      cfg_bias,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_psum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam logic signed [ACC_W:0] OMAX =
    (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] OMIN =
    -OMAX - (ACC_W+1)'(1);

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        n_q;
  logic [CNT_W-1:0]        n_eff;
  logic                    last_psum;
  logic                    in_fire;

  logic signed [ACC_W-1:0] psum_ext;
  logic signed [ACC_W-1:0] bias_ext;

  logic signed [ACC_W-1:0] s1_x;
  logic [4:0]              s1_shift;
  logic                    s1_relu;
  logic                    s1_valid;
  logic                    s1_adv;

  logic signed [ACC_W:0]   xw;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   xr;
  logic signed [ACC_W:0]   r;
  logic [OUT_W-1:0]        q_data;
  logic                    q_sat;

  assign psum_ext = {{(ACC_W-IN_W){in_psum[IN_W-1]}}, in_psum};
  assign bias_ext = {{(ACC_W-16){cfg_bias[15]}}, cfg_bias};

  // Group length comes from cfg on the first psum, the latch after
  always_comb begin
    n_eff = n_q;
    if (cnt == '0) begin
      n_eff = (cfg_num_psum == '0) ? CNT_W'(1) : cfg_num_psum;
    end
  end

  assign last_psum =
    ((CNT_W+1)'(cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(n_eff);

  assign s1_adv   = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s1_adv;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      n_q <= '0;
    end else if (in_fire) begin
      if (cnt == '0) begin
        n_q <= n_eff;
      end
      if (last_psum) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc + psum_ext;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Shift/relu travel with the sum so later cfg edits cannot alter it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x     <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
      s1_valid <= 1'b0;
    end else if (in_fire && last_psum) begin
      s1_x     <= acc + psum_ext + bias_ext;
      s1_shift <= cfg_shift;
      s1_relu  <= cfg_relu;
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    xw  = {s1_x[ACC_W-1], s1_x};
    rnd = '0;
    if (s1_shift != 5'd0) begin
      rnd = (ACC_W+1)'(1) <<< (s1_shift - 5'd1);
    end
    xr = xw + rnd;
    r  = xr >>> s1_shift;
    if (s1_relu && r < 0) begin
      r = '0;
    end
    q_sat  = 1'b0;
    q_data = r[OUT_W-1:0];
    if (r > OMAX) begin
      q_sat  = 1'b1;
      q_data = OMAX[OUT_W-1:0];
    end else if (r < OMIN) begin
      q_sat  = 1'b1;
      q_data = OMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= q_data;
      out_sat   <= q_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofm_requant.sv
// Scoreboard bench for ofm_requant: directed groups, stall,
// reset-discard and throughput cases against hand-computed results.
module tb_ofm_requant;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_num_psum = 8'd1;
  logic [15:0] cfg_bias = '0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_psum = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sat;

  int nvec = 0;
  int nerr = 0;
  int stalls = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  ofm_requant dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_num_psum(cfg_num_psum), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [8:0] e;
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected output: got %0d sat %0b",
                 $signed(out_data), out_sat);
      end else begin
        e = exp_q.pop_front();
        if ({out_sat, out_data} !== e) begin
          nerr++;
          $display("FAIL out: got %0d sat %0b want %0d sat %0b",
                   $signed(out_data), out_sat,
                   $signed(e[7:0]), e[8]);
        end
      end
    end
  end

  task automatic expect_out(input int d, input bit s);
    logic [7:0] d8;
    d8 = d[7:0];
    exp_q.push_back({s, d8});
  endtask

  task automatic cfg(input int n, input int b, input int sh,
                     input bit rl);
    cfg_num_psum = n[7:0];
    cfg_bias     = b[15:0];
    cfg_shift    = sh[4:0];
    cfg_relu     = rl;
  endtask

  // Called just after a rising edge; returns just after the accept edge
  task automatic send(input int p);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_psum  = p[19:0];
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin : main
    logic [39:0] pat;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pass-through and latency
    cfg(1, 0, 0, 0);
    expect_out(100, 0);
    send(100);
    chk("lat_edge1", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_edge2", int'(out_valid), 1);
    drain();

    // 1000+2000-500+12 = 2512, (2512+8)>>4 = 157 -> 127 sat
    cfg(3, 12, 4, 0);
    expect_out(127, 1);
    send(1000); send(2000); send(-500);
    drain();

    cfg(1, 0, 1, 0);
    expect_out(3, 0);   send(5);
    expect_out(-2, 0);  send(-5);
    cfg(1, 0, 1, 1);
    expect_out(0, 0);   send(-300);
    cfg(1, 0, 0, 0);
    expect_out(-128, 1); send(-1000);
    expect_out(127, 0);  send(127);
    expect_out(127, 1);  send(128);
    expect_out(-128, 0); send(-128);
    cfg(1, -20, 0, 0);
    expect_out(-15, 0);  send(5);
    cfg(1, 0, 2, 0);
    expect_out(-1, 0);   send(-6);
    drain();

    // Backpressure: S1 and S2 fill, third psum must wait
    cfg(1, 0, 0, 0);
    out_ready = 1'b0;
    expect_out(1, 0); expect_out(2, 0); expect_out(3, 0);
    send(1); send(2);
    in_valid = 1'b1;
    in_psum  = 20'd3;
    repeat (5) @(negedge clk);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_hold_valid", int'(out_valid), 1);
    chk("stall_hold_data", int'(out_data), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("release_b2b_valid", int'(out_valid), 1);
    end
    drain();

    // Reset mid-group discards the partial sum
    cfg(4, 0, 0, 0);
    send(10); send(20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    expect_out(40, 0);
    send(10); send(10); send(10); send(10);
    drain();

    // N=0 behaves as N=1
    cfg(0, 0, 0, 0);
    expect_out(7, 0); send(7);
    expect_out(7, 0); send(7);
    drain();

    // Full rate with N=1
    cfg(1, 0, 0, 0);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      expect_out(i * 10, 0);
      send(i * 10);
    end
    chk("throughput_stalls", stalls, 0);
    drain();

    // Irregular out_ready, N=2
    cfg(2, 0, 0, 0);
    pat = 40'hA5_3C_96_0F_D2;
    expect_out(7, 0);
    expect_out(8, 0);
    expect_out(-110, 0);
    expect_out(127, 1);
    expect_out(2, 0);
    fork
      begin
        send(3);   send(4);
        send(10);  send(-2);
        send(-50); send(-60);
        send(100); send(100);
        send(1);   send(1);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          out_ready = pat[i];
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
